// File: rtl/song_note_sequencer.sv
// -----------------------------------------------------------------------------
// song_note_sequencer
//
// Note-loading front end for the harmonic chord player. Walks a synchronous
// song ROM one entry at a time and hands each entry to the player as a
// one-cycle load strobe with its note and duration. Advance entries carry
// activate=1. After one of those, the sequencer parks until the player's
// advance counter drains (activate_done) before it fetches further entries.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-low reset
//   play           1 = sequencing enabled, 0 = paused (only gates ISSUE)
//   song           selected song
//   activate_done  player's advance counter is zero
//   rom_addr       {song, entry index}, combinational
//   rom_data       ROM word, valid one cycle after rom_addr
//   note_to_load   note number of the current load (0 when no load)
//   duration       duration in beats of the current load (0 when no load)
//   load_new_note  one-cycle load strobe
//   activate       current load is an advance entry
//   song_done      end of song reached
//
// ROM word: [15] advance, [14:9] note, [8:3] duration, [2:0] reserved.
// An all-zero word ends the song.
// -----------------------------------------------------------------------------
module song_note_sequencer #(
  parameter int SONG_BITS  = 2,
  parameter int ENTRY_BITS = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          activate_done,
  output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
  input  logic [15:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration,
  output logic                          load_new_note,
  output logic                          activate,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_ARM,
    S_WAIT_ADV,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       adv;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] rsvd;
  } entry_t;

  state_t                 state;
  entry_t                 entry;
  logic [ENTRY_BITS-1:0]  idx;
  logic [SONG_BITS-1:0]   song_q;

  logic song_chg;
  logic idx_last;
  logic entry_end;
  logic issue_go;

  // A new song selection aborts whatever is in flight. In IDLE the index is
  // already zero, so a change there needs no action.
  assign song_chg  = (song != song_q) && (state != S_IDLE);
  assign idx_last  = &idx;
  // The end marker is the whole word being zero, reserved bits included.
  assign entry_end = (entry == '0);

  // The strobe is a same-cycle decode: play must be able to hold an entry in
  // ISSUE, and a song change in the ISSUE cycle must suppress the load.
  assign issue_go  = (state == S_ISSUE) && play && !song_chg && !entry_end;

  assign rom_addr  = {song, idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      entry  <= '0;
      song_q <= '0;
    end else begin
      song_q <= song;
      if (song_chg) begin
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            idx <= '0;
            if (play) state <= S_FETCH;
          end
          // rom_addr has been stable for this cycle; capture the word.
          S_FETCH: begin
            entry <= entry_t'(rom_data);
            state <= S_ISSUE;
          end
          S_ISSUE: begin
            if (entry_end) begin
              state <= S_DONE;
            end else if (play) begin
              if (entry.adv) begin
                state <= S_ARM;
              end else if (idx_last) begin
                // Never roll into the next song's entries.
                state <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_FETCH;
              end
            end
          end
          // The player loads its advance counter during this cycle, so
          // activate_done still reflects the previous advance here.
          S_ARM: begin
            if (idx_last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_WAIT_ADV;
            end
          end
          S_WAIT_ADV: begin
            if (activate_done) state <= S_FETCH;
          end
          S_DONE: begin
            if (!play) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    load_new_note = issue_go;
    activate      = issue_go && entry.adv;
    note_to_load  = issue_go ? entry.note : 6'd0;
    duration      = issue_go ? entry.dur  : 6'd0;
    song_done     = (state == S_DONE);
  end

endmodule

// File: tb/tb_song_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_note_sequencer
//
// Directed bench. A ROM model answers within the cycle. A small player model
// counts down the advance duration one beat per cycle to drive
// activate_done. A monitor logs every load strobe with its cycle number, and
// each scenario task checks that log against hand-computed cycle offsets.
// -----------------------------------------------------------------------------
module tb_song_note_sequencer;

  localparam int SB = 2;
  localparam int EB = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              play = 1'b0;
  logic [SB-1:0]     song = '0;
  logic              activate_done;
  logic [SB+EB-1:0]  rom_addr;
  logic [15:0]       rom_data = '0;
  logic [5:0]        note_to_load;
  logic [5:0]        duration;
  logic              load_new_note;
  logic              activate;
  logic              song_done;

  song_note_sequencer #(.SONG_BITS(SB), .ENTRY_BITS(EB)) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .song          (song),
    .activate_done (activate_done),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .note_to_load  (note_to_load),
    .duration      (duration),
    .load_new_note (load_new_note),
    .activate      (activate),
    .song_done     (song_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM: data refreshed mid-cycle, so it is settled before the FETCH edge.
  logic [15:0] rom [0:127];
  always @(negedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Player advance counter: loads the duration on an advance strobe, then
  // drains one beat per cycle.
  logic [5:0] adv_cnt = '0;
  logic       adv_model_en = 1'b1;
  logic       done_drive = 1'b1;
  always @(posedge clk) begin
    if (load_new_note && activate) adv_cnt <= duration;
    else if (adv_cnt != 0)         adv_cnt <= adv_cnt - 6'd1;
  end
  assign activate_done = adv_model_en ? (adv_cnt == 0) : done_drive;

  // Strobe log.
  int         np = 0;
  int         p_cyc  [64];
  logic [5:0] p_note [64];
  logic [5:0] p_dur  [64];
  logic       p_act  [64];
  always @(negedge clk) begin
    if (load_new_note) begin
      if (np < 64) begin
        p_cyc[np]  = cyc;
        p_note[np] = note_to_load;
        p_dur[np]  = duration;
        p_act[np]  = activate;
      end
      np = np + 1;
    end
  end

  function automatic logic [15:0] mk(input logic adv, input int n, input int d);
    return {adv, n[5:0], d[5:0], 3'b000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (song_done) begin
        dc = cyc;
        break;
      end
      tick();
    end
  endtask

  // Park the FSM in IDLE with play low.
  task automatic go_idle;
    play = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    int c0;
    #3;
    checks++;
    if ({load_new_note, activate, song_done, note_to_load, duration} !== '0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ld=%0b act=%0b done=%0b note=%0d dur=%0d addr=%0d expected all 0",
               load_new_note, activate, song_done, note_to_load, duration, rom_addr);
    end
    tick();
    tick();
    reset = 1'b1;
    play  = 1'b1;
    c0 = cyc;
    tick();
    tick();
    checks++;
    if (!(cyc == c0 + 2 && load_new_note === 1'b1 && note_to_load === 6'd5 && duration === 6'd3)) begin
      errors++;
      $display("FAIL first_issue: got ld=%0b note=%0d dur=%0d expected ld=1 note=5 dur=3",
               load_new_note, note_to_load, duration);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({load_new_note, activate, song_done, note_to_load, duration} !== '0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_issue: got ld=%0b act=%0b note=%0d dur=%0d addr=%0d expected all 0",
               load_new_note, activate, note_to_load, duration, rom_addr);
    end
    play = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (load_new_note !== 1'b0 || rom_addr !== 7'd0) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d got ld=%0b addr=%0d expected ld=0 addr=0", i, load_new_note, rom_addr);
      end
    end
    song = 2'd3;
    #1;
    checks++;
    if (rom_addr !== {2'd3, 5'd0}) begin
      errors++;
      $display("FAIL idle_addr: got %0d expected %0d", rom_addr, 7'd96);
    end
  endtask

  task automatic test_chord_advance;
    int c0, base, dc;
    int exp_note [4];
    exp_note = '{20, 24, 27, 0};
    adv_model_en = 1'b1;
    go_idle();
    base = np;
    song = 2'd1;
    play = 1'b1;
    c0 = cyc;
    repeat (12) tick();
    checks++;
    if (rom_addr !== {2'd1, 5'd4} || activate_done !== 1'b0) begin
      errors++;
      $display("FAIL chord_wait: got addr=%0d adv_done=%0b expected addr=36 adv_done=0", rom_addr, activate_done);
    end
    wait_done(60, dc);
    checks++;
    if (dc != c0 + 20) begin
      errors++;
      $display("FAIL chord_done_cycle: got %0d expected %0d", dc - c0, 20);
    end
    checks++;
    if (np - base != 4) begin
      errors++;
      $display("FAIL chord_pulse_count: got %0d expected 4", np - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (p_cyc[base+k] != c0 + 2 + 2*k || p_note[base+k] != exp_note[k][5:0] ||
            p_dur[base+k] != 6'd8 || p_act[base+k] != (k == 3)) begin
          errors++;
          $display("FAIL chord_pulse%0d: got cyc=+%0d note=%0d dur=%0d act=%0b expected cyc=+%0d note=%0d dur=8 act=%0b",
                   k, p_cyc[base+k] - c0, p_note[base+k], p_dur[base+k], p_act[base+k],
                   2 + 2*k, exp_note[k], (k == 3));
        end
      end
    end
  endtask

  task automatic test_pause;
    int c0, base, dc;
    go_idle();
    base = np;
    song = 2'd0;
    play = 1'b1;
    c0 = cyc;
    tick();
    tick();
    tick();
    play = 1'b0;
    repeat (6) tick();
    checks++;
    if (np - base != 1 || load_new_note !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: got %0d pulses ld=%0b expected 1 pulse ld=0", np - base, load_new_note);
    end
    play = 1'b1;
    wait_done(20, dc);
    checks++;
    if (np - base != 2) begin
      errors++;
      $display("FAIL pause_count: got %0d expected 2", np - base);
    end else begin
      checks++;
      if (p_cyc[base+1] != c0 + 9 || p_note[base+1] != 6'd33 || p_dur[base+1] != 6'd12) begin
        errors++;
        $display("FAIL pause_resume: got cyc=+%0d note=%0d dur=%0d expected cyc=+9 note=33 dur=12",
                 p_cyc[base+1] - c0, p_note[base+1], p_dur[base+1]);
      end
    end
  endtask

  task automatic test_zero_advance;
    int base, dc;
    adv_model_en = 1'b0;
    done_drive   = 1'b1;
    go_idle();
    base = np;
    song = 2'd3;
    play = 1'b1;
    wait_done(20, dc);
    checks++;
    if (np - base != 2) begin
      errors++;
      $display("FAIL zadv_count: got %0d expected 2", np - base);
    end else begin
      checks++;
      if (p_cyc[base+1] - p_cyc[base] != 4 || p_act[base] != 1'b1 || p_act[base+1] != 1'b0 ||
          p_dur[base] != 6'd0 || p_note[base+1] != 6'd40) begin
        errors++;
        $display("FAIL zadv_spacing: got gap=%0d act0=%0b act1=%0b dur0=%0d note1=%0d expected gap=4 act0=1 act1=0 dur0=0 note1=40",
                 p_cyc[base+1] - p_cyc[base], p_act[base], p_act[base+1], p_dur[base], p_note[base+1]);
      end
    end
    adv_model_en = 1'b1;
  endtask

  task automatic test_song_change_wait;
    int c0, base, dc;
    go_idle();
    base = np;
    song = 2'd1;
    play = 1'b1;
    c0 = cyc;
    repeat (12) tick();
    song = 2'd2;
    tick();
    checks++;
    if (rom_addr !== {2'd2, 5'd0} || song_done !== 1'b0 || np - base != 4) begin
      errors++;
      $display("FAIL chg_wait_idle: got addr=%0d done=%0b pulses=%0d expected addr=64 done=0 pulses=4",
               rom_addr, song_done, np - base);
    end
    wait_done(20, dc);
    checks++;
    if (np - base != 5 || dc != c0 + 18) begin
      errors++;
      $display("FAIL chg_wait_count: got pulses=%0d done=+%0d expected pulses=5 done=+18", np - base, dc - c0);
    end else begin
      checks++;
      if (p_cyc[base+4] != c0 + 15 || p_note[base+4] != 6'd50 || p_act[base+4] != 1'b0) begin
        errors++;
        $display("FAIL chg_wait_song2: got cyc=+%0d note=%0d act=%0b expected cyc=+15 note=50 act=0",
                 p_cyc[base+4] - c0, p_note[base+4], p_act[base+4]);
      end
    end
  endtask

  task automatic test_song_change_issue;
    int c0, base, dc;
    go_idle();
    base = np;
    song = 2'd0;
    play = 1'b1;
    c0 = cyc;
    tick();
    tick();
    song = 2'd1;
    #1;
    checks++;
    if (load_new_note !== 1'b0) begin
      errors++;
      $display("FAIL chg_issue_strobe: got ld=%0b expected 0", load_new_note);
    end
    wait_done(60, dc);
    checks++;
    if (np - base != 4 || dc != c0 + 23) begin
      errors++;
      $display("FAIL chg_issue_count: got pulses=%0d done=+%0d expected pulses=4 done=+23", np - base, dc - c0);
    end else begin
      checks++;
      if (p_cyc[base] != c0 + 5 || p_note[base] != 6'd20) begin
        errors++;
        $display("FAIL chg_issue_first: got cyc=+%0d note=%0d expected cyc=+5 note=20",
                 p_cyc[base] - c0, p_note[base]);
      end
    end
  endtask

  task automatic test_wrap;
    int c0, base, dc;
    int bad;
    for (int k = 0; k < 32; k++) rom[64 + k] = mk(1'b0, k + 1, 1);
    go_idle();
    base = np;
    song = 2'd2;
    play = 1'b1;
    c0 = cyc;
    wait_done(100, dc);
    repeat (4) tick();
    checks++;
    if (dc != c0 + 65) begin
      errors++;
      $display("FAIL wrap_done_cycle: got +%0d expected +65", dc - c0);
    end
    checks++;
    if (np - base != 32 || song_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count: got pulses=%0d done=%0b expected pulses=32 done=1", np - base, song_done);
    end else begin
      bad = 0;
      for (int k = 0; k < 32; k++) begin
        if (p_cyc[base+k] != c0 + 2 + 2*k || p_note[base+k] != 6'(k + 1) || p_act[base+k] != 1'b0)
          bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL wrap_sequence: got %0d bad entries expected 0", bad);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0]  = mk(1'b0, 5, 3);
    rom[1]  = mk(1'b0, 33, 12);
    rom[32] = mk(1'b0, 20, 8);
    rom[33] = mk(1'b0, 24, 8);
    rom[34] = mk(1'b0, 27, 8);
    rom[35] = mk(1'b1, 0, 8);
    rom[64] = mk(1'b0, 50, 4);
    rom[96] = mk(1'b1, 9, 0);
    rom[97] = mk(1'b0, 40, 2);
    #2 reset = 1'b0;

    test_reset();
    test_chord_advance();
    test_pause();
    test_zero_advance();
    test_song_change_wait();
    test_song_change_issue();
    test_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/song_note_sequencer.md
Name: song_note_sequencer

Overview:
Drives the note-loading side of the harmonic chord player. Walks a synchronous song ROM and issues note loads (note, duration, one-cycle load_new_note strobe) that the player assigns to free voices. Advance entries are issued with activate asserted; the sequencer then waits for the player's advance counter to expire (activate_done) before fetching further entries. Sits between the top-level play/song controls and the chord player.

Parameters:
SONG_BITS, 2, number of song-select bits (4 songs)
ENTRY_BITS, 5, entry-index bits per song (32 entries per song)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
play  in  1  1 = sequencing enabled, 0 = paused
song  in  SONG_BITS  selected song
activate_done  in  1  from chord player: advance counter is zero
rom_addr  out  SONG_BITS+ENTRY_BITS  {song, entry index}
rom_data  in  16  ROM word, valid one cycle after rom_addr
note_to_load  out  6  note number to chord player
duration  out  6  duration in beats to chord player
load_new_note  out  1  one-cycle load strobe
activate  out  1  marks the current load as an advance entry
song_done  out  1  high once the end of song is reached

Behaviour:
- ROM word format: [15] advance flag; [14:9] note; [8:3] duration in beats; [2:0] reserved, ignored. A word that is all zero is the end marker.
- Reset (reset=0, asynchronous) forces the following:
  - state IDLE and entry index 0;
  - rom_addr={song,0};
  - note_to_load=0, duration=0, load_new_note=0, activate=0, song_done=0.
- rom_addr is driven combinationally from {song, entry index}.
- FSM states: IDLE, FETCH, ISSUE, ARM, WAIT_ADV, DONE.
  - IDLE: index=0. Go to FETCH when play=1.
  - FETCH: waits one cycle for ROM latency; rom_data is sampled at the end of this cycle into an entry register. Go to ISSUE.
  - ISSUE, all-zero entry: go to DONE. No strobe is issued.
  - ISSUE, play=0: hold in ISSUE with all outputs low.
  - ISSUE, play=1: assert load_new_note for exactly this cycle, with note_to_load=entry[14:9] and duration=entry[8:3].
    - Advance flag=1: activate=1 in this cycle; go to ARM.
    - Advance flag=0: activate=0; index increments; go to FETCH.
  - ARM: one cycle that lets the player's advance counter load; activate_done is ignored. Index increments; go to WAIT_ADV.
  - WAIT_ADV: go to FETCH on the first cycle with activate_done=1. An advance with duration 0 therefore costs exactly ARM plus one WAIT_ADV cycle.
  - DONE: song_done=1. Hold until song changes or play falls, then go to IDLE.
- Outside ISSUE, load_new_note, activate, note_to_load and duration are all 0.
- Index wrap: if index=2^ENTRY_BITS-1 and it would increment, go to DONE instead.
- Song change: song is registered every cycle. Any change of song while not in IDLE returns the FSM to IDLE on the next cycle. Index clears to 0, song_done clears, and no strobe is issued in that cycle.
  - If a change coincides with an ISSUE cycle, the song change wins: no strobe is issued.
- play=0 in FETCH, ARM or WAIT_ADV does not stall the FSM. Beats are frozen inside the player, so WAIT_ADV naturally stalls. Only ISSUE is gated.
- Voice overflow policy belongs to the player: loads sent while all three voices are busy are dropped by the player. Songs must hold at most 3 simultaneous notes between advances.
- Throughput: one note load every 2 cycles (FETCH, ISSUE) between advances.

Test Plan:
1. Reset/idle: reset=0 mid-ISSUE -> all outputs 0 immediately. After release with play=0: FSM stays IDLE and rom_addr={song,0}.
2. Chord then advance: song 1 = {note 20 dur 8}, {note 24 dur 8}, {note 27 dur 8}, {adv dur 8}, {0}, with play=1.
   - Required: three load_new_note pulses 2 cycles apart carrying 20/24/27 with activate=0.
   - Then one pulse with activate=1 and duration=8.
   - No further fetch until activate_done=1 (driven low 8 beats by the bench model).
   - Then song_done=1.
3. Pause: play=0 while an entry sits in ISSUE -> load_new_note stays 0. play=1 -> exactly one pulse with the held note.
4. Zero-length advance: {adv dur 0}, with activate_done held at 1 -> next fetch starts 2 cycles after the ISSUE cycle.
5. Song change mid-WAIT_ADV: song 1→2 -> FSM returns to IDLE, index 0, rom_addr={2,0}, no stray strobe. Song 2 then plays from its first entry.
6. Wrap: 32 non-zero note entries with no end marker -> 32 pulses, then song_done=1. No entry from the next song is fetched.
